fp_pack_norm: RTL and testbench



---
 rtl/fp_pack_norm_if.sv | 43 ++++
 rtl/fp_pack_norm.sv | 162 ++++++++++++++++
 tb/tb_fp_pack_norm.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp_pack_norm_if.sv
// Handshake bundle for fp_pack_norm: operand input channel and packed-result output channel.
// The master modport drives operands and out_ready; the slave modport is the block itself.
interface fp_pack_norm_if;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [9:0]  exponent_in;
    logic [27:0] mantissa_in;
    logic [31:0] result;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;
    logic        underflow;
    logic        zero;

    modport master (
        output in_valid,
        output sign_in,
        output exponent_in,
        output mantissa_in,
        output out_ready,
        input  in_ready,
        input  result,
        input  out_valid,
        input  overflow,
        input  underflow,
        input  zero
    );

    modport slave (
        input  in_valid,
        input  sign_in,
        input  exponent_in,
        input  mantissa_in,
        input  out_ready,
        output in_ready,
        output result,
        output out_valid,
        output overflow,
        output underflow,
        output zero
    );
endinterface

// File: rtl/fp_pack_norm.sv
// Normalizes an extended mantissa one bit per cycle, optionally rounds to nearest-even
// (macro FP_PACK_ROUND_EN), range-checks and packs an IEEE-754 single-precision word.
module fp_pack_norm (
    input logic           clk,
    input logic           reset,
    fp_pack_norm_if.slave bus_io
);

`ifdef FP_PACK_ROUND_EN
    typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} state_e;
`else
    typedef enum logic [1:0] {StIdle, StNorm, StDone} state_e;
`endif

    localparam logic signed [11:0] ExpMax = 12'sd255;

    state_e             state_q;
    logic               sign_q;
    logic signed [11:0] exp_q;
    logic [27:0]        mant_q;
    logic [31:0]        result_q;
    logic               out_valid_q;
    logic               overflow_q;
    logic               underflow_q;
    logic               zero_q;

    logic [27:0]        mant_rs;
    logic signed [11:0] exp_inc;
    logic [27:0]        chk_mant;
    logic signed [11:0] chk_exp;
    logic [31:0]        chk_result;
    logic               chk_ovf;
    logic               chk_unf;
`ifdef FP_PACK_ROUND_EN
    logic               rnd_up;
    logic [27:0]        mant_sum;
`endif
    logic               unused_chk;

    // Right shift keeps the dropped bits alive in the sticky position.
    always_comb begin
        mant_rs = {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
        exp_inc = exp_q + 12'sd1;
`ifdef FP_PACK_ROUND_EN
        rnd_up   = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
        mant_sum = mant_q + {24'd0, rnd_up, 3'b000};
        if (mant_sum[27]) begin
            chk_mant = {1'b0, mant_sum[27:1]};
            chk_exp  = exp_inc;
        end else begin
            chk_mant = mant_sum;
            chk_exp  = exp_q;
        end
`else
        if (mant_q[27]) begin
            chk_mant = mant_rs;
            chk_exp  = exp_inc;
        end else begin
            chk_mant = mant_q;
            chk_exp  = exp_q;
        end
`endif
        chk_ovf    = 1'b0;
        chk_unf    = 1'b0;
        chk_result = {sign_q, chk_exp[7:0], chk_mant[25:3]};
        if (chk_exp >= ExpMax) begin
            chk_ovf    = 1'b1;
            chk_result = {sign_q, 8'hFF, 23'd0};
        end else if (chk_exp <= 12'sd0) begin
            chk_unf    = 1'b1;
            chk_result = {sign_q, 31'd0};
        end
    end

    assign unused_chk = ^{chk_mant[27:26], chk_mant[2:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus_io.in_valid) begin
                        sign_q  <= bus_io.sign_in;
                        exp_q   <= {{2{bus_io.exponent_in[9]}}, bus_io.exponent_in};
                        mant_q  <= bus_io.mantissa_in;
                        state_q <= StNorm;
                    end
                end
                StNorm: begin
                    // A zero operand spends one cycle here so its latency matches a normalized one.
                    if (mant_q == 28'd0) begin
                        result_q    <= {sign_q, 31'd0};
                        overflow_q  <= 1'b0;
                        underflow_q <= 1'b0;
                        zero_q      <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else if (mant_q[27] || mant_q[26]) begin
`ifdef FP_PACK_ROUND_EN
                        if (mant_q[27]) begin
                            mant_q <= mant_rs;
                            exp_q  <= exp_inc;
                        end
                        state_q <= StRound;
`else
                        result_q    <= chk_result;
                        overflow_q  <= chk_ovf;
                        underflow_q <= chk_unf;
                        zero_q      <= chk_unf;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
`endif
                    end else if (exp_q <= 12'sd1) begin
                        result_q    <= {sign_q, 31'd0};
                        overflow_q  <= 1'b0;
                        underflow_q <= 1'b1;
                        zero_q      <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        mant_q <= {mant_q[26:0], 1'b0};
                        exp_q  <= exp_q - 12'sd1;
                    end
                end
`ifdef FP_PACK_ROUND_EN
                StRound: begin
                    result_q    <= chk_result;
                    overflow_q  <= chk_ovf;
                    underflow_q <= chk_unf;
                    zero_q      <= chk_unf;
                    out_valid_q <= 1'b1;
                    state_q     <= StDone;
                end
`endif
                StDone: begin
                    if (bus_io.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.in_ready  = (state_q == StIdle) && !reset;
    assign bus_io.result    = result_q;
    assign bus_io.out_valid = out_valid_q;
    assign bus_io.overflow  = overflow_q;
    assign bus_io.underflow = underflow_q;
    assign bus_io.zero      = zero_q;

endmodule

// File: tb/tb_fp_pack_norm.sv
// Randomized and directed bench for fp_pack_norm against an arithmetic reference model.
// Builds with or without FP_PACK_ROUND_EN; the model follows the same macro.
module tb_fp_pack_norm;

    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;

    fp_pack_norm_if bus ();

    fp_pack_norm dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        ov;
        logic        un;
        logic        z;
        int          lat;
    } expect_t;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    endtask

    // Value-level model: find the leading one, count shifts, round on the 24-bit significand.
    function automatic expect_t model(input logic s, input logic [9:0] e10, input logic [27:0] m28);
        expect_t r;
        int      e;
        int      p;
        int      need;
        int      avail;
        longint  m;
        longint  f;
        e     = int'($signed(e10));
        m     = longint'(m28);
        r.ov  = 1'b0;
        r.un  = 1'b0;
        r.z   = 1'b0;
        r.lat = 1;
        r.res = {s, 31'd0};
        if (m == 0) begin
            r.z = 1'b1;
            return r;
        end
        p = 0;
        for (int i = 0; i < 28; i++) if (m[i]) p = i;
        if (p == 27) begin
            m = (m >> 1) | (m & 1);
            e = e + 1;
        end else if (p < 26) begin
            need  = 26 - p;
            avail = (e > 1) ? e - 1 : 0;
            if (need > avail) begin
                r.un  = 1'b1;
                r.z   = 1'b1;
                r.lat = 1 + avail;
                return r;
            end
            m     = m << need;
            e     = e - need;
            r.lat = r.lat + need;
        end
`ifdef FP_PACK_ROUND_EN
        r.lat = r.lat + 1;
        f = m >> 3;
        if (m[2] && (m[1] || m[0] || f[0])) f = f + 1;
        if (f >= (longint'(1) << 24)) begin
            f = f >> 1;
            e = e + 1;
        end
        m = f << 3;
`endif
        if (e >= 255) begin
            r.ov  = 1'b1;
            r.res = {s, 8'hFF, 23'd0};
        end else if (e <= 0) begin
            r.un  = 1'b1;
            r.z   = 1'b1;
        end else begin
            r.res = {s, e[7:0], m[25:3]};
        end
        return r;
    endfunction

    task automatic wait_ready();
        int t;
        t = 0;
        while (!bus.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check_val("in_ready_timeout", 64'(bus.in_ready), 64'd1);
    endtask

    task automatic run_op(input string tag, input logic s, input logic [9:0] e,
                          input logic [27:0] m, input int hold);
        expect_t     x;
        int          lat;
        logic [31:0] held;
        logic        stable;
        x = model(s, e, m);
        wait_ready();
        bus.sign_in     = s;
        bus.exponent_in = e;
        bus.mantissa_in = m;
        bus.in_valid    = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!bus.out_valid && lat < 200) begin
            lat++;
            @(negedge clk);
        end
        check_val({tag, "_lat"}, 64'(lat), 64'(x.lat));
        check_val({tag, "_res"}, 64'(bus.result), 64'(x.res));
        check_val({tag, "_flags"}, 64'({bus.overflow, bus.underflow, bus.zero}),
                  64'({x.ov, x.un, x.z}));
        if (hold > 0) begin
            held   = bus.result;
            stable = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (bus.result !== held || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
                    stable = 1'b0;
            end
            check_val({tag, "_hold"}, 64'(stable), 64'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        check_val({tag, "_drop"}, 64'({bus.out_valid, bus.in_ready}), 64'b01);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic        rs;
        logic [9:0]  re;
        logic [27:0] rm;
        logic        seen;
        n_total         = 0;
        n_pass          = 0;
        reset           = 1'b1;
        bus.in_valid    = 1'b0;
        bus.sign_in     = 1'b0;
        bus.exponent_in = '0;
        bus.mantissa_in = '0;
        bus.out_ready   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_outputs", 64'({bus.in_ready, bus.out_valid, bus.result,
                  bus.overflow, bus.underflow, bus.zero}), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_ready", 64'(bus.in_ready), 64'd1);

        run_op("one",     1'b0, 10'd127, 28'h4000000, 0);
        run_op("carry",   1'b0, 10'd127, 28'h8000000, 1);
        run_op("lshift6", 1'b0, 10'd133, 28'h0100000, 0);
        run_op("zero",    1'b1, 10'd50,  28'h0000000, 0);
        run_op("flush",   1'b0, 10'd5,   28'h0000001, 0);
        run_op("ovf_pos", 1'b0, 10'd254, 28'h8000000, 0);
        run_op("ovf_neg", 1'b1, 10'd254, 28'h8000000, 0);
        run_op("rnd_up",  1'b0, 10'd127, 28'h7FFFFFC, 0);
        run_op("rnd_tie", 1'b0, 10'd127, 28'h4000004, 0);
        run_op("neg_exp", 1'b1, 10'h3F0, 28'h4000000, 0);
        run_op("backpr",  1'b0, 10'd130, 28'h5000000, 10);

        // Reset in the middle of a left-shift sequence must discard the operation.
        wait_ready();
        bus.sign_in     = 1'b0;
        bus.exponent_in = 10'd133;
        bus.mantissa_in = 28'h0100000;
        bus.in_valid    = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("midrst_out", 64'({bus.in_ready, bus.out_valid, bus.result,
                  bus.overflow, bus.underflow, bus.zero}), 64'd0);
        reset = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check_val("midrst_spurious", 64'(seen), 64'd0);
        run_op("after_rst", 1'b0, 10'd133, 28'h0100000, 0);

        for (int k = 0; k < 60; k++) begin
            rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) re = 10'($urandom_range(0, 1023));
            else re = 10'(100 + $urandom_range(0, 60));
            rm = 28'($urandom() & 32'h0FFF_FFFF);
            rm = rm >> $urandom_range(0, 27);
            if ($urandom_range(0, 9) == 0) rm = '0;
            run_op("rand", rs, re, rm, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
